// File: rtl/iir_biquad_mac_sched.sv
`default_nettype none
// ============================================================================
// Module  : iir_biquad_mac_sched
// Purpose : Time-multiplexed direct-form-I biquad. One registered signed
//           multiplier is sequenced through five products per sample,
//           y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2. The result is
//           floor-truncated to the sample format and saturated.
//           Coefficients are written to shadow registers and committed to
//           the active set when the next sample is accepted.
// Ports   : CLK, RST (async, active low)
//           in_data/in_valid/in_ready     : sample input handshake
//           coef_we/coef_addr/coef_data   : coefficient shadow write port
//           hist_clr                      : clear history, abort computation
//           out_data/out_valid/out_sat    : result, 1-cycle pulse, clamp flag
// Revision: 1.0 - initial release
// ============================================================================
module iir_biquad_mac_sched #(
  parameter int WI  = 4,
  parameter int WF  = 12,
  parameter int WIC = 2,
  parameter int WFC = 14,
  parameter int WG  = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WI+WF-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               coef_we,
  input  logic [2:0]         coef_addr,
  input  logic [WIC+WFC-1:0] coef_data,
  input  logic               hist_clr,
  output logic [WI+WF-1:0]   out_data,
  output logic               out_valid,
  output logic               out_sat
);

  localparam int WS = WI + WF;    // sample width
  localparam int WC = WIC + WFC;  // coefficient width
  localparam int WP = WS + WC;    // full-precision product width
  localparam int WA = WG + WP;    // accumulator width
  localparam int WR = WA - WFC;   // accumulator after dropping WFC fraction bits

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL0  = 3'd1;
  localparam logic [2:0] S_MUL1  = 3'd2;
  localparam logic [2:0] S_MUL2  = 3'd3;
  localparam logic [2:0] S_MUL3  = 3'd4;
  localparam logic [2:0] S_MUL4  = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;
  localparam logic [2:0] S_OUT   = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [WS-1:0] x_q, x_d, x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
  logic [WA-1:0] acc_q, acc_d;
  logic [WP-1:0] prod_q, prod_d;
  logic [WC-1:0] shadow_q [5];
  logic [WC-1:0] active_q [5];
  logic          pending_q, pending_d;
  logic [WS-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sat_q, out_sat_d;

  logic          accept;
  logic          wr_ok;
  logic [WS-1:0] op_s;
  logic [WC-1:0] op_c;
  logic [WP-1:0] op_s_ext, op_c_ext;
  logic [WA-1:0] prod_ext;
  logic [WR-1:0] rs;
  logic          ovf;
  logic [WS-1:0] y_sat;

  assign in_ready = (state_q == S_IDLE);
  // hist_clr wins over an accept on the same edge
  assign accept   = in_valid & in_ready & ~hist_clr;
  assign wr_ok    = coef_we & (coef_addr < 3'd5);

  // Operand issue: one (coefficient, sample) pair per MUL state
  always_comb begin
    op_s = '0;
    op_c = '0;
    case (state_q)
      S_MUL0: begin op_s = x_q;  op_c = active_q[0]; end
      S_MUL1: begin op_s = x1_q; op_c = active_q[1]; end
      S_MUL2: begin op_s = x2_q; op_c = active_q[2]; end
      S_MUL3: begin op_s = y1_q; op_c = active_q[3]; end
      S_MUL4: begin op_s = y2_q; op_c = active_q[4]; end
      default: ;
    endcase
  end

  // Sign-extend both operands to the product width so an unsigned
  // WP x WP multiply yields the exact signed product in its low WP bits.
  assign op_s_ext = {{WC{op_s[WS-1]}}, op_s};
  assign op_c_ext = {{WS{op_c[WC-1]}}, op_c};
  assign prod_d   = op_s_ext * op_c_ext;
  assign prod_ext = {{WG{prod_q[WP-1]}}, prod_q};

  // Dropping the low bits of a two's-complement value is a floor.
  assign rs    = acc_q[WA-1:WFC];
  assign ovf   = (rs[WR-1:WS-1] != {(WR-WS+1){rs[WR-1]}});
  assign y_sat = ovf ? {rs[WR-1], {(WS-1){~rs[WR-1]}}} : rs[WS-1:0];

  // The product register lags issue by one state, so MUL1..MUL3 add
  // products 0..2 and MUL4/DRAIN subtract the feedback products 3..4.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_sat_d   = 1'b0;
    pending_d   = (pending_q & ~accept) | wr_ok;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d     = in_data;
          acc_d   = '0;
          state_d = S_MUL0;
        end
      end
      S_MUL0: state_d = S_MUL1;
      S_MUL1: begin acc_d = acc_q + prod_ext; state_d = S_MUL2;  end
      S_MUL2: begin acc_d = acc_q + prod_ext; state_d = S_MUL3;  end
      S_MUL3: begin acc_d = acc_q + prod_ext; state_d = S_MUL4;  end
      S_MUL4: begin acc_d = acc_q - prod_ext; state_d = S_DRAIN; end
      S_DRAIN: begin acc_d = acc_q - prod_ext; state_d = S_OUT;  end
      S_OUT: begin
        out_valid_d = 1'b1;
        out_sat_d   = ovf;
        out_data_d  = y_sat;
        x2_d        = x1_q;
        x1_d        = x_q;
        y2_d        = y1_q;
        y1_d        = y_sat;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (hist_clr) begin
      state_d     = S_IDLE;
      x1_d        = '0;
      x2_d        = '0;
      y1_d        = '0;
      y2_d        = '0;
      acc_d       = '0;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      out_sat_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      pending_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      pending_q   <= pending_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
      // Commit reads the pre-write shadow; a same-edge write stays pending.
      for (int i = 0; i < 5; i++) begin
        if (accept && pending_q) active_q[i] <= shadow_q[i];
        if (wr_ok && (coef_addr == 3'(i))) shadow_q[i] <= coef_data;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_iir_biquad_mac_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_iir_biquad_mac_sched
// Purpose : Self-checking bench for iir_biquad_mac_sched. Directed vector
//           table, hand-written sequences for commit/abort/reset corners, and
//           random samples compared against an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_iir_biquad_mac_sched;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        hist_clr = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_sat;

  always #5 CLK = ~CLK;

  iir_biquad_mac_sched dut (
    .CLK(CLK), .RST(RST),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .hist_clr(hist_clr),
    .out_data(out_data), .out_valid(out_valid), .out_sat(out_sat)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  int m_sh [5];
  int m_act [5];
  bit m_pend;
  int m_x1, m_x2, m_y1, m_y2;

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 5; i++) begin m_sh[i] = 0; m_act[i] = 0; end
    m_pend = 0;
    m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
  endtask

  task automatic m_clear();
    m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
  endtask

  task automatic m_write(input logic [2:0] a, input logic [15:0] d);
    if (int'(a) < 5) begin
      m_sh[int'(a)] = sx(d);
      m_pend = 1;
    end
  endtask

  // y = (b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2) / 2^14, floored, clamped
  task automatic m_accept(input logic [15:0] x, output logic [15:0] ey, output logic es);
    longint s;
    longint q;
    int xv;
    xv = sx(x);
    if (m_pend) begin
      m_act = m_sh;
      m_pend = 0;
    end
    s = longint'(m_act[0]) * xv + longint'(m_act[1]) * m_x1 + longint'(m_act[2]) * m_x2
        - longint'(m_act[3]) * m_y1 - longint'(m_act[4]) * m_y2;
    q  = s >>> 14;
    es = 1'b0;
    if (q > 32767) begin q = 32767; es = 1'b1; end
    else if (q < -32768) begin q = -32768; es = 1'b1; end
    ey   = q[15:0];
    m_x2 = m_x1; m_x1 = xv;
    m_y2 = m_y1; m_y1 = int'(q);
  endtask

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; in_valid = 1'b0; coef_we = 1'b0; hist_clr = 1'b0;
    tick(); tick();
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_sat", out_sat, 0);
    check("rst_data", out_data, 0);
    RST = 1'b1;
    tick();
    m_reset();
  endtask

  task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    tick();
    coef_we = 1'b0;
    m_write(a, d);
  endtask

  task automatic clear_hist();
    hist_clr = 1'b1;
    tick();
    hist_clr = 1'b0;
    m_clear();
  endtask

  task automatic accept(input logic [15:0] x, input bit we, input logic [2:0] a,
                        input logic [15:0] d, output logic [15:0] ey, output logic es);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("ready_before_accept", in_ready, 1);
    in_data = x; in_valid = 1'b1;
    coef_we = we; coef_addr = a; coef_data = d;
    tick();
    in_valid = 1'b0; coef_we = 1'b0;
    in_data = 16'($urandom);
    m_accept(x, ey, es);
    if (we) m_write(a, d);
  endtask

  // lat0 = edges already elapsed since the accept edge
  task automatic wait_out(input int lat0, input logic [15:0] ey, input logic es, input string tag);
    int lat;
    bit rdy_bad;
    lat = lat0;
    rdy_bad = 0;
    while (!out_valid && lat < 20) begin
      if (in_ready) rdy_bad = 1;
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 7);
    check({tag, "_ready_low"}, rdy_bad, 0);
    check({tag, "_y"}, out_data, ey);
    check({tag, "_sat"}, out_sat, es);
    tick();
    check({tag, "_pulse"}, out_valid, 0);
  endtask

  task automatic count_no_valid(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check(tag, seen, 0);
  endtask

  function automatic logic [15:0] rand_coef();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit          clr;
    logic [15:0] b0;
    logic [15:0] a1;
    logic [15:0] x;
    logic [15:0] y;
    bit          sat;
  } vec_t;

  vec_t vecs [9];

  logic [15:0] ey;
  logic        es;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 16'h4000, 16'h0000, 16'h0800, 16'h0800, 1'b0};
    vecs[1] = '{1'b1, 16'h4000, 16'hE000, 16'h1000, 16'h1000, 1'b0};
    vecs[2] = '{1'b0, 16'h4000, 16'hE000, 16'h0000, 16'h0800, 1'b0};
    vecs[3] = '{1'b0, 16'h4000, 16'hE000, 16'h0000, 16'h0400, 1'b0};
    vecs[4] = '{1'b0, 16'h4000, 16'hE000, 16'h0000, 16'h0200, 1'b0};
    vecs[5] = '{1'b1, 16'h6000, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1};
    vecs[6] = '{1'b1, 16'h6000, 16'h0000, 16'h8000, 16'h8000, 1'b1};
    vecs[7] = '{1'b1, 16'h2000, 16'h0000, 16'h0001, 16'h0000, 1'b0};
    vecs[8] = '{1'b1, 16'h2000, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].clr) clear_hist();
      write_coef(3'd0, vecs[i].b0);
      write_coef(3'd1, 16'h0000);
      write_coef(3'd2, 16'h0000);
      write_coef(3'd3, vecs[i].a1);
      write_coef(3'd4, 16'h0000);
      accept(vecs[i].x, 1'b0, 3'd0, 16'h0, ey, es);
      wait_out(0, vecs[i].y, vecs[i].sat, "vec");
    end

    // Shadow write during MUL applies only to the following sample
    do_reset();
    write_coef(3'd0, 16'h4000);
    accept(16'h1000, 1'b0, 3'd0, 16'h0, ey, es);
    tick();
    write_coef(3'd0, 16'h2000);
    wait_out(2, 16'h1000, 1'b0, "shadow_old");
    clear_hist();
    accept(16'h1000, 1'b0, 3'd0, 16'h0, ey, es);
    wait_out(0, 16'h0800, 1'b0, "shadow_new");

    // Write on the accept edge: this sample uses the old b0, next one the new
    accept(16'h1000, 1'b1, 3'd0, 16'h4000, ey, es);
    wait_out(0, 16'h0800, 1'b0, "same_edge_old");
    accept(16'h1000, 1'b0, 3'd0, 16'h0, ey, es);
    wait_out(0, 16'h1000, 1'b0, "same_edge_new");

    // Address 5..7 writes are ignored
    write_coef(3'd5, 16'h7FFF);
    write_coef(3'd7, 16'h7FFF);
    clear_hist();
    accept(16'h0800, 1'b0, 3'd0, 16'h0, ey, es);
    wait_out(0, 16'h0800, 1'b0, "addr_ignored");

    // hist_clr while the k=2 pair is issued aborts the sample
    do_reset();
    write_coef(3'd0, 16'h4000);
    write_coef(3'd1, 16'h4000);
    write_coef(3'd3, 16'hE000);
    accept(16'h1000, 1'b0, 3'd0, 16'h0, ey, es);
    wait_out(0, ey, es, "pre_abort");
    accept(16'h0800, 1'b0, 3'd0, 16'h0, ey, es);
    tick(); tick();
    clear_hist();
    check("abort_ready", in_ready, 1);
    count_no_valid(12, "abort_no_valid");
    accept(16'h0400, 1'b0, 3'd0, 16'h0, ey, es);
    wait_out(0, 16'h0400, 1'b0, "after_abort");

    // Asynchronous reset during DRAIN
    accept(16'h1000, 1'b0, 3'd0, 16'h0, ey, es);
    for (int i = 0; i < 5; i++) tick();
    #2;
    RST = 1'b0;
    #1;
    check("rstmid_ready", in_ready, 1);
    check("rstmid_valid", out_valid, 0);
    check("rstmid_data", out_data, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    m_reset();
    count_no_valid(12, "rstmid_no_valid");
    accept(16'h1000, 1'b0, 3'd0, 16'h0, ey, es);
    wait_out(0, 16'h0000, 1'b0, "rstmid_coef_zero");

    // Random samples against the reference model
    do_reset();
    for (int a = 0; a < 5; a++) write_coef(3'(a), rand_coef());
    for (int it = 0; it < 60; it++) begin
      int r;
      r = int'($urandom_range(0, 7));
      if (r == 0) clear_hist();
      if (r == 1) write_coef(3'($urandom_range(0, 7)), rand_coef());
      if (r == 2) begin
        accept(16'($urandom), 1'b1, 3'($urandom_range(0, 7)), rand_coef(), ey, es);
        wait_out(0, ey, es, "rand_we_accept");
      end else if (r == 3) begin
        accept(16'($urandom), 1'b0, 3'd0, 16'h0, ey, es);
        tick();
        write_coef(3'($urandom_range(0, 4)), rand_coef());
        wait_out(2, ey, es, "rand_we_mul");
      end else begin
        accept(16'($urandom), 1'b0, 3'd0, 16'h0, ey, es);
        wait_out(0, ey, es, "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
